// File: rtl/fp_mul_result_buffer.sv
// Registered FIFO stage behind the combinational FP multiplier, with sticky exception flags.
// Optional saturating event counters are built when FP_MUL_RESULT_STATS_EN is defined.
module fp_mul_result_buffer #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int FIFO_DEPTH     = 4,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_result,
    input  logic                                  in_underflow,
    input  logic                                  in_overflow,
    input  logic                                  in_invalid,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_result,
    output logic [2:0]                            out_flags,
    input  logic                                  flush,
    input  logic                                  flags_clear,
`ifdef FP_MUL_RESULT_STATS_EN
    output logic [STAT_WIDTH-1:0]                 stat_result_count,
    output logic [STAT_WIDTH-1:0]                 stat_overflow_count,
    output logic [STAT_WIDTH-1:0]                 stat_underflow_count,
    output logic [STAT_WIDTH-1:0]                 stat_invalid_count,
`endif
    output logic [2:0]                            sticky_flags
);

    localparam int FW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    logic [FW+2:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [2:0]    in_flags;

    assign in_flags  = {in_invalid, in_overflow, in_underflow};
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Head is read straight from the array, so it stays put until popped.
    assign out_result = mem[rd_ptr][FW-1:0];
    assign out_flags  = mem[rd_ptr][FW+2:FW];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_flags, in_result};
    end

    // Clear applies before the same-cycle push sets new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (flags_clear) begin
            sticky_flags <= push ? in_flags : 3'b000;
        end else if (push) begin
            sticky_flags <= sticky_flags | in_flags;
        end
    end

`ifdef FP_MUL_RESULT_STATS_EN
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_result_count    <= '0;
            stat_overflow_count  <= '0;
            stat_underflow_count <= '0;
            stat_invalid_count   <= '0;
        end else if (flags_clear) begin
            stat_result_count    <= STAT_WIDTH'(push);
            stat_overflow_count  <= STAT_WIDTH'(push && in_overflow);
            stat_underflow_count <= STAT_WIDTH'(push && in_underflow);
            stat_invalid_count   <= STAT_WIDTH'(push && in_invalid);
        end else if (push) begin
            stat_result_count <= sat_inc(stat_result_count);
            if (in_overflow)  stat_overflow_count  <= sat_inc(stat_overflow_count);
            if (in_underflow) stat_underflow_count <= sat_inc(stat_underflow_count);
            if (in_invalid)   stat_invalid_count   <= sat_inc(stat_invalid_count);
        end
    end
`else
    localparam int unused_stat_width = STAT_WIDTH;
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Bench for fp_mul_result_buffer: directed vector table, hand-written corner sequences, randomized queue model.
module tb_fp_mul_result_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_underflow, in_overflow, in_invalid;
    logic        out_valid, out_ready, flush, flags_clear;
    logic [31:0] in_result, out_result;
    logic [2:0]  out_flags, sticky_flags;
`ifdef FP_MUL_RESULT_STATS_EN
    logic [3:0]  stat_result_count, stat_overflow_count, stat_underflow_count, stat_invalid_count;
`endif

    int tests = 0;
    int fails = 0;

    fp_mul_result_buffer #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .FIFO_DEPTH(4), .STAT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_underflow(in_underflow), .in_overflow(in_overflow), .in_invalid(in_invalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .flush(flush), .flags_clear(flags_clear),
`ifdef FP_MUL_RESULT_STATS_EN
        .stat_result_count(stat_result_count), .stat_overflow_count(stat_overflow_count),
        .stat_underflow_count(stat_underflow_count), .stat_invalid_count(stat_invalid_count),
`endif
        .sticky_flags(sticky_flags)
    );

    typedef struct {
        logic        r, fl, v;
        logic [31:0] res;
        logic [2:0]  f;
        logic        ordy, clr;
        logic        e_ir, e_ov;
        logic [31:0] e_res;
        logic [2:0]  e_fl, e_st;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic v, input logic [31:0] res,
                         input logic [2:0] f, input logic ordy, input logic clr);
        rst = r; flush = fl; in_valid = v; in_result = res;
        {in_invalid, in_overflow, in_underflow} = f;
        out_ready = ordy; flags_clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    // Reference model: a bounded queue of {flags, result} plus a sticky OR register.
    logic [34:0] mq[$];
    logic [2:0]  msticky;
    logic [31:0] w[5];
    logic [31:0] got[$];
    logic        sent4;

    initial begin
        //               r     fl    v     res           f       ordy  clr   | ir    ov    head          flags   sticky
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h3FC00000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3FC00000, 3'b000, 3'b000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7F800000, 3'b010, 3'b010};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7F800000, 3'b010, 3'b011};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7F800000, 3'b010, 3'b011};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7F800000, 3'b010, 3'b000};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h7FC00000, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000, 3'b001, 3'b000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 3'b100, 3'b100};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 3'b100, 3'b100};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'b000, 3'b100};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        tick();

        // Directed table: each row checks the state seen before its own edge.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].fl, tbl[i].v, tbl[i].res, tbl[i].f, tbl[i].ordy, tbl[i].clr);
            #1;
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_sticky", i), 32'(sticky_flags), 32'(tbl[i].e_st));
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d_out_result", i), out_result, tbl[i].e_res);
                check($sformatf("tbl%0d_out_flags", i), 32'(out_flags), 32'(tbl[i].e_fl));
            end
            tick();
        end

        // Backpressure: fill to depth, hold a fifth word, then drain in order.
        do_reset();
        w[0] = 32'h3F800000; w[1] = 32'h40000000; w[2] = 32'h40400000;
        w[3] = 32'h40800000; w[4] = 32'h40A00000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, w[i], 3'b000, 1'b0, 1'b0);
            #1;
            check($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, w[4], 3'b000, 1'b0, 1'b0);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head", out_result, w[0]);
        tick();
        check("stall_head_stable", out_result, w[0]);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        sent4 = 1'b0;
        got.delete();
        for (int cyc = 0; cyc < 20 && got.size() < 5; cyc++) begin
            drive(1'b0, 1'b0, !sent4, w[4], 3'b000, 1'b1, 1'b0);
            #1;
            if (cyc == 0) check("drain_first_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) sent4 = 1'b1;
            if (out_valid) got.push_back(out_result);
            tick();
        end
        check("drain_count", got.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("drain%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, w[i]);

        // Flush keeps sticky; reset mid-stream clears everything.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h7F800000, 3'b010, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 32'h11111111, 3'b000, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 32'h22222222, 3'b000, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 32'h33333333, 3'b000, 1'b0, 1'b0);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_pre_out_valid", 32'(out_valid), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_sticky", 32'(sticky_flags), 32'b010);
        check("flush_after_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h00000001 + 32'(i), 3'b001, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h44444444, 3'b000, 1'b1, 1'b0);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'b000);
        check("rst_after_in_ready", 32'(in_ready), 32'd1);
        tick();

`ifdef FP_MUL_RESULT_STATS_EN
        do_reset();
        #1;
        check("stat_reset", 32'(stat_result_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h7F800000, 3'b010, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        #1;
        check("stat_ovf_sat", 32'(stat_overflow_count), 32'd15);
        check("stat_res_sat", 32'(stat_result_count), 32'd15);
        check("stat_udf_zero", 32'(stat_underflow_count), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h7FC00000, 3'b100, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        #1;
        check("stat_clr_res", 32'(stat_result_count), 32'd1);
        check("stat_clr_inv", 32'(stat_invalid_count), 32'd1);
        check("stat_clr_ovf", 32'(stat_overflow_count), 32'd0);
        tick();
`endif

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete();
        msticky = 3'b000;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic r, fl, v, ordy, clr, e_ir, e_ov, p_push, p_pop;
            logic [31:0] res;
            logic [2:0]  f;
            r    = ($urandom_range(99, 0) < 1);
            fl   = ($urandom_range(99, 0) < 3);
            v    = ($urandom_range(99, 0) < 60);
            ordy = ($urandom_range(99, 0) < 50);
            clr  = ($urandom_range(99, 0) < 5);
            res  = $urandom;
            f    = 3'($urandom_range(7, 0));
            drive(r, fl, v, res, f, ordy, clr);
            #1;
            e_ir = !r && !fl && (mq.size() < 4);
            e_ov = (mq.size() != 0);
            check("rnd_in_ready", 32'(in_ready), 32'(e_ir));
            check("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            check("rnd_sticky", 32'(sticky_flags), 32'(msticky));
            if (e_ov) begin
                check("rnd_out_result", out_result, mq[0][31:0]);
                check("rnd_out_flags", 32'(out_flags), 32'(mq[0][34:32]));
            end
            p_push = v && e_ir;
            p_pop  = e_ov && ordy && !fl;
            if (r) begin
                mq.delete();
                msticky = 3'b000;
            end else begin
                if (fl) mq.delete();
                else begin
                    if (p_pop) void'(mq.pop_front());
                    if (p_push) mq.push_back({f, res});
                end
                if (clr) msticky = p_push ? f : 3'b000;
                else if (p_push) msticky = msticky | f;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
